// File: rtl/mat_operand_streamer_if.sv
// -----------------------------------------------------------------------------
// mat_operand_streamer_if
// Bundles the load port, the start/status signals and the two operand streams
// (A and B) of mat_operand_streamer.
//   master : the streamer side (drives o_* signals, receives i_* signals)
//   slave  : the controller/consumer side (drives i_* signals)
// Signals:
//   i_load_we/i_load_sel/i_load_addr/i_load_data : operand storage write port
//   i_start                                      : begin streaming
//   o_busy/o_done                                : run status
//   o_x_num/o_x_num_valid/o_x_last/i_x_read      : per-stream valid/read strobe
// -----------------------------------------------------------------------------
interface mat_operand_streamer_if #(
    parameter int N  = 3,
    parameter int W  = 8,
    parameter int AW = $clog2(N*N)
);
    logic          i_load_we;
    logic          i_load_sel;
    logic [AW-1:0] i_load_addr;
    logic [W-1:0]  i_load_data;
    logic          i_start;
    logic          o_busy;
    logic          o_done;
    logic [W-1:0]  o_a_num;
    logic          o_a_num_valid;
    logic          o_a_last;
    logic          i_a_read;
    logic [W-1:0]  o_b_num;
    logic          o_b_num_valid;
    logic          o_b_last;
    logic          i_b_read;

    modport master (
        input  i_load_we, i_load_sel, i_load_addr, i_load_data, i_start,
        input  i_a_read, i_b_read,
        output o_busy, o_done,
        output o_a_num, o_a_num_valid, o_a_last,
        output o_b_num, o_b_num_valid, o_b_last
    );

    modport slave (
        output i_load_we, i_load_sel, i_load_addr, i_load_data, i_start,
        output i_a_read, i_b_read,
        input  o_busy, o_done,
        input  o_a_num, o_a_num_valid, o_a_last,
        input  o_b_num, o_b_num_valid, o_b_last
    );
endinterface

// File: rtl/mat_operand_streamer.sv
// -----------------------------------------------------------------------------
// mat_operand_streamer
// Holds two NxN operand matrices A and B and, on a start pulse, streams them in
// the order a matrix multiplier consumes them: for every C[r][c] (row-major),
// k runs 0..N-1, A presents A[r][k] and B presents B[k][c]. Each stream has its
// own counters and advances only when its consumer reads a valid element.
// Ports:
//   i_clk  : clock, rising edge
//   i_rst  : synchronous active-high reset (also clears operand storage)
//   bus    : mat_operand_streamer_if.master (load port, start, status, streams)
// -----------------------------------------------------------------------------
module mat_operand_streamer #(
    parameter int N  = 3,
    parameter int W  = 8,
    parameter int AW = $clog2(N*N)
) (
    input  logic                          i_clk,
    input  logic                          i_rst,
    mat_operand_streamer_if.master        bus
);
    localparam int NN = N * N;
    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_DONE} state_t;

    state_t r_state;
    logic   r_busy;
    logic   r_done;

    logic            w_go;
    logic            w_load_ok;
    logic [1:0]      w_read;
    logic [1:0]      w_valid;
    logic [1:0]      w_last;
    logic [1:0]      w_still_valid;
    logic [1:0][W-1:0] w_num;

    // Loads and starts are only honoured in IDLE; a load and a start in the
    // same IDLE cycle both land on the same edge.
    assign w_go      = (r_state == S_IDLE) && bus.i_start;
    assign w_load_ok = (r_state == S_IDLE) && bus.i_load_we && (int'(bus.i_load_addr) < NN);
    assign w_read    = {bus.i_b_read, bus.i_a_read};

    // Stream 0 is A, stream 1 is B. Both share the same r/c/k walk; only the
    // storage index differs.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : gen_stream
        logic [W-1:0]  r_mem [NN];
        logic [CW-1:0] r_row;
        logic [CW-1:0] r_col;
        logic [CW-1:0] r_k;
        logic          r_valid;
        logic [AW-1:0] w_idx;
        logic          w_end;
        logic          w_take;

        if (gi == 0) begin : gen_a_idx
            assign w_idx = AW'(r_row) * AW'(N) + AW'(r_k);
        end else begin : gen_b_idx
            assign w_idx = AW'(r_k) * AW'(N) + AW'(r_col);
        end

        assign w_end  = (r_row == LAST_IDX) && (r_col == LAST_IDX) && (r_k == LAST_IDX);
        assign w_take = r_valid && w_read[gi];

        assign w_valid[gi]       = r_valid;
        assign w_last[gi]        = r_valid && w_end;
        // Valid as it will be after this edge; drives the STREAM->DONE decision.
        assign w_still_valid[gi] = r_valid && !(w_take && w_end);
        // Data is a combinational storage read; it is forced to 0 when the
        // stream is not presenting an element so reset/idle outputs are 0.
        assign w_num[gi]         = r_valid ? r_mem[w_idx] : '0;

        always_ff @(posedge i_clk) begin
            if (i_rst) begin
                for (int e = 0; e < NN; e++) begin
                    r_mem[e] <= '0;
                end
                r_row   <= '0;
                r_col   <= '0;
                r_k     <= '0;
                r_valid <= 1'b0;
            end else begin
                if (w_load_ok && (bus.i_load_sel == 1'(gi))) begin
                    r_mem[bus.i_load_addr] <= bus.i_load_data;
                end
                if (w_go) begin
                    r_row   <= '0;
                    r_col   <= '0;
                    r_k     <= '0;
                    r_valid <= 1'b1;
                end else if (w_take) begin
                    if (w_end) begin
                        // Final element consumed: stream stays exhausted.
                        r_valid <= 1'b0;
                    end else if (r_k != LAST_IDX) begin
                        r_k <= r_k + 1'b1;
                    end else begin
                        r_k <= '0;
                        if (r_col != LAST_IDX) begin
                            r_col <= r_col + 1'b1;
                        end else begin
                            r_col <= '0;
                            r_row <= r_row + 1'b1;
                        end
                    end
                end
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.i_start) begin
                        r_state <= S_STREAM;
                        r_busy  <= 1'b1;
                    end
                end
                S_STREAM: begin
                    // Leave as soon as the later stream's final read happens.
                    if (w_still_valid == 2'b00) begin
                        r_state <= S_DONE;
                        r_busy  <= 1'b0;
                        r_done  <= 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign bus.o_busy        = r_busy;
    assign bus.o_done        = r_done;
    assign bus.o_a_num       = w_num[0];
    assign bus.o_a_num_valid = w_valid[0];
    assign bus.o_a_last      = w_last[0];
    assign bus.o_b_num       = w_num[1];
    assign bus.o_b_num_valid = w_valid[1];
    assign bus.o_b_last      = w_last[1];

endmodule

// File: tb/tb_mat_operand_streamer.sv
// -----------------------------------------------------------------------------
// tb_mat_operand_streamer
// Table-driven bench: each record holds the inputs for one cycle and the
// outputs expected in the following cycle. Streaming runs are expanded into
// records from the expected element order; reset and same-edge load/start
// corners are written out by hand.
// -----------------------------------------------------------------------------
module tb_mat_operand_streamer;
    localparam int N  = 3;
    localparam int W  = 8;
    localparam int AW = $clog2(N*N);
    localparam int NE = N * N * N;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mat_operand_streamer_if #(.N(N), .W(W), .AW(AW)) bus ();

    mat_operand_streamer #(.N(N), .W(W), .AW(AW)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .bus   (bus)
    );

    typedef struct {
        string         tag;
        bit            rst;
        bit            start;
        bit            we;
        bit            sel;
        logic [AW-1:0] addr;
        logic [W-1:0]  data;
        bit            ar;
        bit            br;
        logic [W-1:0]  ea;
        bit            eav;
        bit            eal;
        logic [W-1:0]  eb;
        bit            ebv;
        bit            ebl;
        bit            ebusy;
        bit            edone;
        bit            ezero;   // also require both data outputs to be 0
    } vec_t;

    vec_t vq[$];
    int   n_vec = 0;
    int   n_bad = 0;

    // Element n of each stream with A and B loaded as 1..N*N row-major.
    function automatic logic [W-1:0] a_val(int n);
        return W'((n / (N*N)) * N + (n % N) + 1);
    endfunction

    function automatic logic [W-1:0] b_val(int n);
        return W'((n % N) * N + ((n / N) % N) + 1);
    endfunction

    function automatic vec_t blank(string tag);
        vec_t v;
        v.tag = tag;  v.rst = 1'b0; v.start = 1'b0; v.we = 1'b0; v.sel = 1'b0;
        v.addr = '0;  v.data = '0;  v.ar = 1'b0;    v.br = 1'b0;
        v.ea = '0;    v.eav = 1'b0; v.eal = 1'b0;
        v.eb = '0;    v.ebv = 1'b0; v.ebl = 1'b0;
        v.ebusy = 1'b0; v.edone = 1'b0; v.ezero = 1'b0;
        return v;
    endfunction

    function automatic vec_t set_exp(vec_t vin, int na, int nb);
        vec_t v = vin;
        v.eav = (na < NE);
        v.ea  = v.eav ? a_val(na) : '0;
        v.eal = v.eav && (na == NE - 1);
        v.ebv = (nb < NE);
        v.eb  = v.ebv ? b_val(nb) : '0;
        v.ebl = v.ebv && (nb == NE - 1);
        return v;
    endfunction

    // One streaming run: start, then reads each cycle (A toggled if asked),
    // optionally with ignored start/load at cycle 5, stopping after n_cycles
    // read cycles if n_cycles > 0.
    function automatic void add_run(string tag, bit a_toggle, bit inject, int n_cycles);
        vec_t v;
        int na = 0;
        int nb = 0;
        v = blank({tag, "-start"});
        v.start = 1'b1;
        v.ar    = 1'b1;     // read while idle must be ignored
        v = set_exp(v, 0, 0);
        v.ebusy = 1'b1;
        vq.push_back(v);
        for (int i = 0; i < 4 * NE; i++) begin
            if (n_cycles > 0 && i == n_cycles) return;
            v = blank(tag);
            v.ar = !a_toggle || (i % 2 == 0);
            v.br = 1'b1;
            if (inject && i == 5) begin
                v.start = 1'b1; v.we = 1'b1; v.sel = 1'b0; v.addr = '0; v.data = 8'hFF;
            end
            if (v.ar && na < NE) na++;
            if (v.br && nb < NE) nb++;
            v = set_exp(v, na, nb);
            if (na == NE && nb == NE) begin
                v.edone = 1'b1;
                vq.push_back(v);
                break;
            end
            v.ebusy = 1'b1;
            vq.push_back(v);
        end
        v = blank({tag, "-idle"});
        v.ar = 1'b1;
        v.br = 1'b1;
        vq.push_back(v);
    endfunction

    task automatic apply(input vec_t v);
        bit ok;
        rst              = v.rst;
        bus.i_start      = v.start;
        bus.i_load_we    = v.we;
        bus.i_load_sel   = v.sel;
        bus.i_load_addr  = v.addr;
        bus.i_load_data  = v.data;
        bus.i_a_read     = v.ar;
        bus.i_b_read     = v.br;
        @(posedge clk);
        #1;
        n_vec++;
        ok = (bus.o_a_num_valid === v.eav) && (bus.o_a_last === v.eal) &&
             (bus.o_b_num_valid === v.ebv) && (bus.o_b_last === v.ebl) &&
             (bus.o_busy === v.ebusy) && (bus.o_done === v.edone);
        if (v.eav || v.ezero) ok = ok && (bus.o_a_num === v.ea);
        if (v.ebv || v.ezero) ok = ok && (bus.o_b_num === v.eb);
        if (!ok) begin
            n_bad++;
            $display("FAIL vec %0d %s: got a=%02h v%0b l%0b b=%02h v%0b l%0b busy%0b done%0b, want a=%02h v%0b l%0b b=%02h v%0b l%0b busy%0b done%0b",
                     n_vec, v.tag, bus.o_a_num, bus.o_a_num_valid, bus.o_a_last,
                     bus.o_b_num, bus.o_b_num_valid, bus.o_b_last, bus.o_busy, bus.o_done,
                     v.ea, v.eav, v.eal, v.eb, v.ebv, v.ebl, v.ebusy, v.edone);
        end else begin
            $display("vec %0d %s: a=%02h v%0b l%0b b=%02h v%0b l%0b busy%0b done%0b",
                     n_vec, v.tag, bus.o_a_num, bus.o_a_num_valid, bus.o_a_last,
                     bus.o_b_num, bus.o_b_num_valid, bus.o_b_last, bus.o_busy, bus.o_done);
        end
    endtask

    initial begin
        vec_t v;
        bus.i_start = 1'b0; bus.i_load_we = 1'b0; bus.i_load_sel = 1'b0;
        bus.i_load_addr = '0; bus.i_load_data = '0;
        bus.i_a_read = 1'b0; bus.i_b_read = 1'b0;

        // Reset values.
        for (int i = 0; i < 2; i++) begin
            v = blank("reset"); v.rst = 1'b1; v.ezero = 1'b1; vq.push_back(v);
        end

        // Load A and B with 1..N*N, plus out-of-range writes that must be dropped.
        for (int i = 0; i < N*N; i++) begin
            v = blank("load-a"); v.we = 1'b1; v.sel = 1'b0; v.addr = AW'(i); v.data = W'(i + 1);
            vq.push_back(v);
            v = blank("load-b"); v.we = 1'b1; v.sel = 1'b1; v.addr = AW'(i); v.data = W'(i + 1);
            vq.push_back(v);
        end
        v = blank("load-oob"); v.we = 1'b1; v.sel = 1'b0; v.addr = AW'(N*N); v.data = 8'hEE;
        vq.push_back(v);
        v = blank("load-oob"); v.we = 1'b1; v.sel = 1'b1; v.addr = '1; v.data = 8'hEE;
        vq.push_back(v);

        add_run("basic",  1'b0, 1'b0, 0);
        add_run("stall",  1'b1, 1'b0, 0);
        add_run("inject", 1'b0, 1'b1, 0);
        add_run("rerun",  1'b0, 1'b0, 0);
        add_run("rstmid", 1'b0, 1'b0, 10);

        // Reset mid-stream, then restart on cleared storage.
        v = blank("rstmid-rst"); v.rst = 1'b1; v.ar = 1'b1; v.br = 1'b1; v.ezero = 1'b1;
        vq.push_back(v);
        v = blank("rst-restart"); v.start = 1'b1; v.eav = 1'b1; v.ebv = 1'b1; v.ebusy = 1'b1; v.ezero = 1'b1;
        vq.push_back(v);
        for (int i = 0; i < 2; i++) begin
            v = blank("rst-zero"); v.ar = 1'b1; v.br = 1'b1;
            v.eav = 1'b1; v.ebv = 1'b1; v.ebusy = 1'b1; v.ezero = 1'b1;
            vq.push_back(v);
        end
        v = blank("rst2"); v.rst = 1'b1; v.ezero = 1'b1;
        vq.push_back(v);

        // Same-edge load of A[0]=0x55 and start; A[0][0] reappears at element 3.
        v = blank("same-edge"); v.start = 1'b1; v.we = 1'b1; v.sel = 1'b0; v.addr = '0; v.data = 8'h55;
        v.ea = 8'h55; v.eav = 1'b1; v.ebv = 1'b1; v.ebusy = 1'b1;
        vq.push_back(v);
        v = blank("same-edge-n1"); v.ar = 1'b1; v.br = 1'b1; v.eav = 1'b1; v.ebv = 1'b1; v.ebusy = 1'b1;
        vq.push_back(v);
        v = blank("same-edge-n2"); v.ar = 1'b1; v.eav = 1'b1; v.ebv = 1'b1; v.ebusy = 1'b1;
        vq.push_back(v);
        v = blank("same-edge-n3"); v.ar = 1'b1; v.ea = 8'h55; v.eav = 1'b1; v.ebv = 1'b1; v.ebusy = 1'b1;
        vq.push_back(v);
        v = blank("final-rst"); v.rst = 1'b1; v.ezero = 1'b1;
        vq.push_back(v);

        for (int i = 0; i < vq.size(); i++) begin
            apply(vq[i]);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
